// File: rtl/e203_itcm_load_arb.sv
// ITCM load arbiter: packs a loader byte stream into 64-bit ITCM words while the core is
// held in reset, then hands the SRAM port to the core. Optional: ITCM_LOAD_CHECKSUM_EN.
module e203_itcm_load_arb #(
  parameter int AW    = 13,
  parameter int DEPTH = 8192
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  input  logic          core_cs,
  input  logic          core_we,
  input  logic [7:0]    core_wem,
  input  logic [AW-1:0] core_addr,
  input  logic [63:0]   core_din,
  output logic          core_gnt,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [7:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [63:0]   ram_din,
  output logic          core_rst_n_o,
  output logic          load_done,
  output logic [AW:0]   load_words,
  output logic          ovf_err,
  output logic [31:0]   ld_checksum
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_RUN} state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [63:0]  buf_q, buf_d;
  logic [7:0]   mask_q, mask_d;
  logic [AW:0]  words_q, words_d;
  logic         ovf_q, ovf_d;
  logic         last_q, last_d;
  logic         accept, full, restart;

  assign accept  = (state_q == S_LOAD) && ld_valid;
  assign full    = (words_q == DEPTH_W);
  assign restart = load_start && ((state_q == S_IDLE) || (state_q == S_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      mask_q  <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (load_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          buf_d   = '0;
          mask_d  = '0;
          words_d = '0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          buf_d[8*idx_q +: 8] = ld_byte;
          mask_d[idx_q]       = 1'b1;
          idx_d               = idx_q + 3'd1;
          if ((idx_q == 3'd7) || ld_last) begin
            state_d = S_WRITE;
            last_d  = ld_last;
          end
        end
      end
      S_WRITE: begin
        // The word address is the write count, so saturating the count also stops the address.
        if (full) ovf_d   = 1'b1;
        else      words_d = words_q + (AW+1)'(1);
        idx_d   = '0;
        buf_d   = '0;
        mask_d  = '0;
        state_d = last_q ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (state_q == S_WRITE) begin
      ram_cs   = !full;
      ram_we   = 1'b1;
      ram_wem  = mask_q;
      ram_addr = words_q[AW-1:0];
      ram_din  = buf_q;
    end else if (state_q == S_RUN) begin
      ram_cs   = core_cs;
      ram_we   = core_we;
      ram_wem  = core_wem;
      ram_addr = core_addr;
      ram_din  = core_din;
    end
  end

  assign ld_ready     = (state_q == S_LOAD);
  assign core_gnt     = (state_q == S_RUN);
  assign core_rst_n_o = (state_q == S_RUN);
  assign load_done    = (state_q == S_DONE) || (state_q == S_RUN);
  assign load_words   = words_q;
  assign ovf_err      = ovf_q;

`ifdef ITCM_LOAD_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      csum_q <= '0;
    else if (restart) csum_q <= '0;
    else if (accept)  csum_q <= csum_q + {24'd0, ld_byte};
  end
  assign ld_checksum = csum_q;
`else
  assign ld_checksum = '0;
  logic unused_restart;
  assign unused_restart = restart;
`endif

endmodule

// File: tb/tb_e203_itcm_load_arb.sv
// Randomized bench for e203_itcm_load_arb with a word-level image model and write scoreboard.
module tb_e203_itcm_load_arb;
  localparam int AW = 4, DEPTH = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0] ld_byte = '0;
  logic ld_ready;
  logic core_cs = 1'b0, core_we = 1'b0;
  logic [7:0] core_wem = '0;
  logic [AW-1:0] core_addr = '0;
  logic [63:0] core_din = '0;
  logic core_gnt, ram_cs, ram_we, core_rst_n_o, load_done, ovf_err;
  logic [7:0] ram_wem;
  logic [AW-1:0] ram_addr;
  logic [63:0] ram_din;
  logic [AW:0] load_words;
  logic [31:0] ld_checksum;

  e203_itcm_load_arb #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte), .ld_last(ld_last),
    .core_cs(core_cs), .core_we(core_we), .core_wem(core_wem), .core_addr(core_addr),
    .core_din(core_din), .core_gnt(core_gnt),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr), .ram_din(ram_din),
    .core_rst_n_o(core_rst_n_o), .load_done(load_done), .load_words(load_words),
    .ovf_err(ovf_err), .ld_checksum(ld_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    m;
    logic [63:0]   d;
  } wr_t;

  wr_t wr_q[$];
  int  last_wr_cyc = 0;

  // Only loader-side writes are recorded; any core leak before RUN shows up as an extra entry.
  always @(negedge clk)
    if (rst_n && ram_cs && ram_we && !core_gnt) begin
      wr_q.push_back(wr_t'{a: ram_addr, m: ram_wem, d: ram_din});
      last_wr_cyc <= cyc;
    end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  logic [7:0] img[$];
  bit gaps, noise;

  task automatic core_noise();
    if (noise) begin
      core_cs = 1'b1; core_we = 1'b1; core_wem = 8'hFF;
      core_addr = AW'($urandom); core_din = {$urandom, $urandom};
    end else begin
      core_cs = 1'b0; core_we = 1'b0; core_wem = '0; core_addr = '0; core_din = '0;
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    core_noise();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("start_ready", ld_ready, 1);
    chk("start_gnt", core_gnt, 0);
    chk("start_core_rst", core_rst_n_o, 0);
    chk("start_words", load_words, 0);
    chk("start_ovf", ovf_err, 0);
    chk("start_done", load_done, 0);
    wr_q.delete();
  endtask

  task automatic send(input int nmax);
    int i = 0;
    int guard = 0;
    while (i < nmax && guard < 2000) begin
      @(negedge clk);
      guard++;
      core_noise();
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_byte  = img[i];
        ld_last  = (i == img.size() - 1);
        if (ld_ready) i++;
      end
    end
    if (i != nmax) chk("send_timeout", i, nmax);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic finish_and_check();
    int nw, exp_w, t;
    logic [31:0] sum;
    logic [63:0] d;
    logic [7:0]  m;
    nw    = (img.size() + 7) / 8;
    exp_w = (nw > DEPTH) ? DEPTH : nw;
    t = 0;
    while (!core_rst_n_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("run_reached", core_rst_n_o, 1);
    if (nw <= DEPTH) chk("run_latency", cyc - last_wr_cyc, 2);
    noise = 0;
    core_noise();
    chk("n_writes", wr_q.size(), exp_w);
    for (int k = 0; k < exp_w; k++) begin
      d = '0;
      m = '0;
      for (int j = 0; j < 8; j++)
        if (8*k + j < img.size()) begin
          d[8*j +: 8] = img[8*k + j];
          m[j] = 1'b1;
        end
      if (k < wr_q.size()) begin
        chk("wr_addr", wr_q[k].a, k);
        chk("wr_wem", wr_q[k].m, m);
        chk("wr_din", wr_q[k].d, d);
      end
    end
    sum = '0;
`ifdef ITCM_LOAD_CHECKSUM_EN
    foreach (img[i]) sum += 32'(img[i]);
`endif
    chk("load_words", load_words, exp_w);
    chk("ovf_err", ovf_err, nw > DEPTH);
    chk("load_done", load_done, 1);
    chk("core_gnt", core_gnt, 1);
    chk("checksum", ld_checksum, sum);
  endtask

  initial begin
    #2;
    chk("rst_ready", ld_ready, 0);
    chk("rst_gnt", core_gnt, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wem", ram_wem, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_core_rst", core_rst_n_o, 0);
    chk("rst_done", load_done, 0);
    chk("rst_words", load_words, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_csum", ld_checksum, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two full words, ld_last on the final byte
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    gaps = 0; noise = 0;
    start_load();
    send(16);
    finish_and_check();
    if (wr_q.size() == 2) begin
      chk("t1_w0", wr_q[0].d, 64'h0706050403020100);
      chk("t1_w1", wr_q[1].d, 64'h0F0E0D0C0B0A0908);
    end
`ifdef ITCM_LOAD_CHECKSUM_EN
    chk("t1_csum", ld_checksum, 32'h78);
`endif

    // Core passthrough in RUN is combinational
    @(negedge clk);
    core_cs = 1'b1; core_we = 1'b1; core_wem = 8'hF0; core_addr = 4'd5; core_din = 64'h1122334455667788;
    #1;
    chk("pt_cs", ram_cs, 1);
    chk("pt_we", ram_we, 1);
    chk("pt_wem", ram_wem, 8'hF0);
    chk("pt_addr", ram_addr, 5);
    chk("pt_din", ram_din, 64'h1122334455667788);
    noise = 0;
    core_noise();

    // Partial word
    img = '{8'hAA, 8'hBB, 8'hCC};
    start_load();
    send(3);
    finish_and_check();
    if (wr_q.size() == 1) begin
      chk("t2_wem", wr_q[0].m, 8'h07);
      chk("t2_din", wr_q[0].d, 64'h0000000000CCBBAA);
    end

    // Overflow with core hammering the port throughout
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    gaps = 1; noise = 1;
    start_load();
    send(20);
    finish_and_check();
    chk("t3_ovf", ovf_err, 1);

    // Restart from RUN clears the flags (checked inside start_load), then abort by reset
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    gaps = 0; noise = 0;
    start_load();
    send(5);
    rst_n = 1'b0;
    #1;
    chk("ar_ready", ld_ready, 0);
    chk("ar_ram_cs", ram_cs, 0);
    chk("ar_core_rst", core_rst_n_o, 0);
    chk("ar_words", load_words, 0);
    chk("ar_csum", ld_checksum, 0);
    chk("ar_no_write", wr_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_load();
    send(12);
    finish_and_check();

    for (int r = 0; r < 8; r++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) img.push_back(8'($urandom));
      gaps  = bit'($urandom_range(0, 1));
      noise = bit'($urandom_range(0, 1));
      start_load();
      send(img.size());
      finish_and_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/e203_itcm_load_arb.md
Name: e203_itcm_load_arb

Overview:
- Simulation/bring-up controller for the ITCM SRAM port.
- Takes a byte stream from a loader (testbench DPI, UART or debug bridge) and packs it little-endian into 64-bit ITCM words.
- Holds the core in reset while loading, then hands the SRAM port to the core.
- Replaces hierarchical backdoor preload with a real, synthesizable load path that the test benches sequence.

Parameters:
- AW, 13, ITCM word address width.
- DEPTH, 8192, number of 64-bit ITCM words (must be <= 2^AW).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse; begins or restarts a load
- ld_valid  in  1  loader byte valid
- ld_ready  out  1  loader byte accept
- ld_byte  in  8  loader data byte
- ld_last  in  1  marks final byte of image; qualified by ld_valid
- core_cs  in  1  core SRAM chip select
- core_we  in  1  core write enable
- core_wem  in  8  core byte write mask
- core_addr  in  AW  core word address
- core_din  in  64  core write data
- core_gnt  out  1  core owns SRAM port
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_wem  out  8  SRAM byte mask
- ram_addr  out  AW  SRAM word address
- ram_din  out  64  SRAM write data
- core_rst_n_o  out  1  core reset, active low
- load_done  out  1  level; image fully written
- load_words  out  AW+1  number of words written in the last load
- ovf_err  out  1  sticky; image exceeded DEPTH
- ld_checksum  out  32  byte checksum (see Optional Feature)

Behaviour:
- Reset values: FSM=IDLE; ld_ready=0; core_gnt=0; ram_cs/ram_we=0; ram_wem=0; ram_addr=0; ram_din=0; core_rst_n_o=0; load_done=0; load_words=0; ovf_err=0; ld_checksum=0.
- SRAM contents are never cleared by this block.
- IDLE:
  - load_start -> LOAD.
  - Clears byte index, word address, load_words, ovf_err, checksum, load_done.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready, the byte is stored at lane idx (bits 8*idx+7:8*idx), mask bit idx is set, and idx increments.
  - If idx was 7, or ld_last=1, go to WRITE and latch last_seen=ld_last.
- WRITE (1 cycle):
  - ld_ready=0.
  - ram_cs=1, ram_we=1, ram_wem=accumulated mask, ram_addr=waddr, ram_din=packed word; unreceived lanes are 0.
  - Next cycle: waddr+1, load_words+1, buffer/mask/idx cleared.
  - If load_words==DEPTH at entry: ram_cs=0 (write suppressed), ovf_err=1, counters unchanged.
  - Next state: last_seen ? DONE : LOAD.
  - Throughput: 8 bytes per 9 cycles.
- DONE (1 cycle): load_done=1 -> RUN.
- RUN:
  - core_rst_n_o=1, core_gnt=1.
  - ram_* = core_* passthrough (combinational mux).
  - load_done holds 1.
- Outside RUN: core_gnt=0; core_* ignored (ram_cs from the core path forced 0); core_rst_n_o=0.
- load_start behaviour by state:
  - RUN: restart. core_rst_n_o=0 and core_gnt=0 on the next cycle; state LOAD with counters and flags cleared as in IDLE.
  - LOAD, WRITE or DONE: ignored.
- ld_valid without ld_ready: byte is not consumed; the loader must hold it.
- Asynchronous reset mid-load: immediate return to IDLE. A partial word is lost, and previously written words remain in the SRAM.
- load_words saturates at DEPTH. The word address never wraps.

Optional Feature:
- Macro ITCM_LOAD_CHECKSUM_EN.
- Defined: ld_checksum is the 32-bit modulo-2^32 sum of every accepted byte (zero-extended) since the last load_start. It updates the cycle after each accept and includes bytes dropped due to overflow.
- Undefined: ld_checksum tied to 0; no adder is instantiated.

Test Plan:
- Reset, load_start, bytes 0x00..0x0F, ld_last on 0x0F. Expect:
  - write addr0, wem=0xFF, din=0x0706050403020100;
  - write addr1, din=0x0F0E0D0C0B0A0908;
  - load_words=2, load_done=1, core_rst_n_o=1 two cycles after the second write;
  - checksum=0x78 when the macro is defined.
- 3-byte image 0xAA,0xBB,0xCC with last. Expect one write at addr0, wem=0x07, din=0x0000000000CCBBAA, load_words=1.
- DEPTH=2, 20-byte image. Expect:
  - two writes, third write suppressed (ram_cs=0);
  - ovf_err=1, load_words=2;
  - FSM still reaches RUN.
- core_cs=1, core_we=1 held throughout load. Expect core_gnt=0, no core write reaches ram_*. In RUN, core_addr=5, wem=0xF0 appear on ram_* in the same cycle.
- rst_n pulsed low after 5 bytes. Expect all outputs at reset values immediately, no write issued; a fresh load then completes normally.
- load_start pulse in RUN. Expect core_rst_n_o=0 and core_gnt=0 next cycle, load_words=0, ovf_err=0, ld_ready=1.
